exposure_timer_ctrl: RTL and testbench
======================================

Name: exposure_timer_ctrl

Overview:
Programmable exposure timer for the pixel-array camera controller. It holds the user-adjustable exposure time, set with the Exp_increase/Exp_decrease buttons. When the exposure FSM pulses Start, it counts exposure cycles and returns a one-cycle Ovf5 pulse to the FSM. It sits beside the exposure FSM, consumes its Start output, drives its Ovf5 input, and ignores settings changes while an exposure is running.

Parameters:
EXP_W, 5, width of exposure setting and counter
EXP_MIN, 2, minimum exposure time in Clk cycles
EXP_MAX, 30, maximum exposure time in Clk cycles
EXP_DEFAULT, 5, exposure time after Init

Ports:
Clk  input  1  system clock (1 ms period in system benches)
Init  input  1  asynchronous reset, active-high
Exp_increase  input  1  button level; each rising edge adds 1 to the setting
Exp_decrease  input  1  button level; each rising edge subtracts 1 from the setting
Start  input  1  from exposure FSM; a rising edge begins timing
Abort  input  1  from FSM user-reset line; level, cancels a running count
Ovf5  output  1  single-cycle pulse when exposure time has elapsed
Exp_time  output  EXP_W  current exposure setting
Busy  output  1  high while a count is in progress

Behaviour:
- Init asserted (any time, asynchronous) -> state IDLE, Exp_time=EXP_DEFAULT, counter=0, Ovf5=0, Busy=0, edge-detector history=0.
- Edge detect: rise = in & ~in_q, with in_q registered every cycle on Start, Exp_increase and Exp_decrease. A held button counts once.
- Setting, IDLE only:
  - inc rise -> Exp_time+1, saturating at EXP_MAX.
  - dec rise -> Exp_time-1, saturating at EXP_MIN.
  - inc and dec rise in the same cycle -> no change.
  - Button edges arriving in any other state are discarded, not queued.
- States: IDLE, COUNT, DONE. Busy = (state != IDLE), registered.
- IDLE:
  - Start rise sampled at edge k and Abort low -> latch active = Exp_time, counter <= 1, go to COUNT.
  - Start rise and inc/dec rise in the same cycle -> Start wins; the button edge is discarded.
- COUNT:
  - Abort high -> IDLE next edge, no Ovf5.
  - Otherwise, counter == active -> DONE with Ovf5 <= 1; else counter <= counter+1.
  - Start edges are ignored.
- DONE: Ovf5 <= 0, go to IDLE. Ovf5 is high for exactly one cycle.
- Latency: Start rise sampled at edge k -> Ovf5 high from edge k+N to edge k+N+1, where N = latched Exp_time. Busy is high from edge k+1 through edge k+N+1.
- Width: the counter never exceeds EXP_MAX (30 < 2^5), so there is no wrap. Exp_time stays within [EXP_MIN, EXP_MAX] at all times.
- Start held high after DONE does not retrigger; a new rising edge is required.

Decomposition:
- Shared package (camera_pkg): EXP_W, EXP_MIN, EXP_MAX, EXP_DEFAULT, and the timer state encoding (IDLE=0, COUNT=1, DONE=2). The exposure FSM bench reuses the same constants.
- One sub-module: rise_edge_detect (1-bit register plus AND, async Init), instantiated three times.

Test Plan:
- Init pulse at t=0 -> Exp_time=5, Ovf5=0, Busy=0 before the first Clk edge; all outputs reset immediately even with Clk stopped.
- Start rise, default setting -> Ovf5 high for exactly 1 cycle, 5 cycles after the Start sample edge; Busy high for 6 cycles; held Start does not retrigger.
- 30 inc edges from 5 -> Exp_time 30 (saturated); then 40 dec edges -> 2. A button held 10 cycles changes the value by 1 only. Simultaneous inc+dec -> unchanged.
- Exp_time=10, inc edges during COUNT -> Exp_time stays 10; Ovf5 arrives 10 cycles after Start.
- Exp_time=10, Abort at cycle 3 of the count -> no Ovf5, Busy low next edge; a following Start gives Ovf5 after 10 cycles.
- Init asserted mid-count (cycle 4 of 8) -> Busy=0, Ovf5=0, Exp_time=5 immediately; no Ovf5 after Init releases.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera controller constants, timer state encoding and exposure stepping helper.
package camera_pkg;

    localparam int unsigned EXP_W       = 5;
    localparam int unsigned EXP_MIN     = 2;
    localparam int unsigned EXP_MAX     = 30;
    localparam int unsigned EXP_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } timer_state_e;

    // One saturating step of the exposure setting; opposite edges together cancel out.
    function automatic logic [EXP_W-1:0] exp_step(
        input logic [EXP_W-1:0] cur,
        input logic             up,
        input logic             dn
    );
        logic [EXP_W-1:0] nxt;
        nxt = cur;
        if (up && !dn && (cur < EXP_W'(EXP_MAX))) begin
            nxt = cur + EXP_W'(1);
        end else if (dn && !up && (cur > EXP_W'(EXP_MIN))) begin
            nxt = cur - EXP_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Single-bit rising-edge detector: one history flop plus an AND.
module rise_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic rise_c_o
);

    logic in_q;

    // Previous-cycle sample of the input.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign rise_c_o = in_i & ~in_q;

endmodule

// File: rtl/exposure_timer_ctrl.sv
// Programmable exposure timer: holds the button-adjusted exposure setting and,
// on a Start edge, counts that many cycles before pulsing Ovf5 for one cycle.
module exposure_timer_ctrl
    import camera_pkg::*;
(
    input  logic             Clk,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    input  logic             Start,
    input  logic             Abort,
    output logic             Ovf5,
    output logic [EXP_W-1:0] Exp_time,
    output logic             Busy
);

    logic             start_rise;
    logic             inc_rise;
    logic             dec_rise;

    timer_state_e     state_q;
    logic [EXP_W-1:0] exp_time_q;
    logic [EXP_W-1:0] active_q;
    logic [EXP_W-1:0] cnt_q;
    logic             ovf_q;
    logic             busy_q;

    rise_edge_detect u_start_edge (
        .clk_i    (Clk),
        .rst_i    (Init),
        .in_i     (Start),
        .rise_c_o (start_rise)
    );

    rise_edge_detect u_inc_edge (
        .clk_i    (Clk),
        .rst_i    (Init),
        .in_i     (Exp_increase),
        .rise_c_o (inc_rise)
    );

    rise_edge_detect u_dec_edge (
        .clk_i    (Clk),
        .rst_i    (Init),
        .in_i     (Exp_decrease),
        .rise_c_o (dec_rise)
    );

    // Timer FSM: setting updates in IDLE, cycle count in COUNT, one-cycle Ovf5 into DONE.
    always_ff @(posedge Clk or posedge Init) begin
        if (Init) begin
            state_q    <= ST_IDLE;
            exp_time_q <= EXP_W'(EXP_DEFAULT);
            active_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ovf_q  <= 1'b0;
            busy_q <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start_rise && !Abort) begin
                        // Start takes priority; any coincident button edge is dropped.
                        active_q <= exp_time_q;
                        cnt_q    <= EXP_W'(1);
                        state_q  <= ST_COUNT;
                    end else begin
                        exp_time_q <= exp_step(exp_time_q, inc_rise, dec_rise);
                    end
                end
                ST_COUNT: begin
                    if (Abort) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == active_q) begin
                        ovf_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + EXP_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ovf5     = ovf_q;
    assign Exp_time = exp_time_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Self-checking bench for exposure_timer_ctrl: scoreboard of expected Ovf5 cycles
// plus directed checks of the exposure setting, Busy and asynchronous Init.
module tb_exposure_timer_ctrl;
    import camera_pkg::*;

    logic             Clk;
    logic             Init;
    logic             Exp_increase;
    logic             Exp_decrease;
    logic             Start;
    logic             Abort;
    logic             Ovf5;
    logic [EXP_W-1:0] Exp_time;
    logic             Busy;

    logic             clk_en;
    int               cyc;
    int               checks;
    int               errors;
    int               ovf_seen;
    int               exp_m;
    int               busy_cnt;
    int               ovf_q[$];

    exposure_timer_ctrl dut (
        .Clk          (Clk),
        .Init         (Init),
        .Exp_increase (Exp_increase),
        .Exp_decrease (Exp_decrease),
        .Start        (Start),
        .Abort        (Abort),
        .Ovf5         (Ovf5),
        .Exp_time     (Exp_time),
        .Busy         (Busy)
    );

    // Gated clock so reset can be checked with the clock stopped.
    initial begin
        Clk = 1'b0;
        forever begin
            #5;
            if (clk_en) Clk = ~Clk;
        end
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, req, cyc);
        end
    endtask

    // Scoreboard consumer: every Ovf5 cycle must match the next expected edge index.
    always @(posedge Clk) begin
        #1;
        if (Ovf5 === 1'b1) begin
            if (ovf_q.size() == 0) begin
                check("ovf_unexpected", 32'(Ovf5), 32'd0);
            end else begin
                check("ovf_time", 32'(cyc), 32'(ovf_q.pop_front()));
                ovf_seen++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic press(input logic up, input logic dn, input bit track);
        Exp_increase = up;
        Exp_decrease = dn;
        tick(1);
        Exp_increase = 1'b0;
        Exp_decrease = 1'b0;
        tick(1);
        if (track) begin
            if (up && !dn && exp_m < int'(EXP_MAX)) exp_m++;
            else if (dn && !up && exp_m > int'(EXP_MIN)) exp_m--;
        end
    endtask

    // Raise Start now; the next edge samples it and Ovf5 follows exp_m edges later.
    task automatic start_expect(input bit expect_ovf);
        Start = 1'b1;
        if (expect_ovf) ovf_q.push_back(cyc + 1 + exp_m);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; checks = 0; errors = 0; ovf_seen = 0;
        clk_en = 1'b0;
        Init = 1'b1;
        Exp_increase = 1'b0; Exp_decrease = 1'b0; Start = 1'b0; Abort = 1'b0;
        exp_m = int'(EXP_DEFAULT);

        // Reset with clock stopped
        #2;
        check("rst_exp_time", 32'(Exp_time), 32'd5);
        check("rst_ovf5", 32'(Ovf5), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        clk_en = 1'b1;
        tick(2);
        Init = 1'b0;
        tick(2);

        // Default exposure, Start held high afterwards
        start_expect(1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (Busy === 1'b1) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd6);
        tick(8);
        Start = 1'b0;
        tick(1);
        check("held_start_busy", 32'(Busy), 32'd0);

        // Saturation up and down
        for (int i = 0; i < 30; i++) press(1'b1, 1'b0, 1'b1);
        check("sat_max", 32'(Exp_time), 32'(exp_m));
        check("sat_max_abs", 32'(Exp_time), 32'd30);
        for (int i = 0; i < 40; i++) press(1'b0, 1'b1, 1'b1);
        check("sat_min", 32'(Exp_time), 32'd2);

        // Held button counts once
        Exp_increase = 1'b1;
        tick(10);
        Exp_increase = 1'b0;
        tick(1);
        exp_m++;
        check("held_inc", 32'(Exp_time), 32'd3);

        // Simultaneous inc and dec cancel
        press(1'b1, 1'b1, 1'b1);
        check("inc_dec_same", 32'(Exp_time), 32'd3);

        // Set to 10, then button edges during COUNT are discarded
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b1);
        check("set_ten", 32'(Exp_time), 32'd10);
        start_expect(1'b1);
        tick(1);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0);
        check("count_busy", 32'(Busy), 32'd1);
        tick(10);
        check("count_ignores_inc", 32'(Exp_time), 32'd10);

        // Abort during count
        start_expect(1'b0);
        tick(1);
        Start = 1'b0;
        tick(2);
        Abort = 1'b1;
        tick(2);
        check("abort_busy", 32'(Busy), 32'd0);
        Abort = 1'b0;
        tick(14);
        start_expect(1'b1);
        tick(1);
        Start = 1'b0;
        tick(14);
        check("after_abort_idle", 32'(Busy), 32'd0);

        // Init mid-count at cycle 4 of 8
        press(1'b0, 1'b1, 1'b1);
        press(1'b0, 1'b1, 1'b1);
        check("set_eight", 32'(Exp_time), 32'd8);
        start_expect(1'b0);
        tick(1);
        Start = 1'b0;
        tick(3);
        #2;
        Init = 1'b1;
        #1;
        check("init_busy", 32'(Busy), 32'd0);
        check("init_ovf5", 32'(Ovf5), 32'd0);
        check("init_exp_time", 32'(Exp_time), 32'd5);
        exp_m = int'(EXP_DEFAULT);
        tick(2);
        Init = 1'b0;
        tick(12);
        check("post_init_exp", 32'(Exp_time), 32'(exp_m));
        check("post_init_busy", 32'(Busy), 32'd0);

        // Scoreboard drained
        check("sb_empty", 32'(ovf_q.size()), 32'd0);
        check("ovf_count", 32'(ovf_seen), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
